// File: rtl/nrx_hiscore_pkg.sv
// Shared types and constants for the New Rally-X hi-score save/restore controller.
package nrx_hiscore_pkg;

    localparam int HS_PORT_AW = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHK_RD  = 2'd1,
        ST_RESTORE = 2'd2,
        ST_UP_RD   = 2'd3
    } hs_state_e;

    // Index width for a buffer of len bytes; never narrower than one bit.
    function automatic int idx_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/nrx_hs_buf.sv
// Hi-score image buffer: host-side synchronous write port, restore-side asynchronous read port.
module nrx_hs_buf
    import nrx_hiscore_pkg::*;
#(
    parameter int LEN = 64,
    parameter int IW  = idx_width(LEN)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [IW-1:0] raddr,
    output logic [7:0]    rdata
);

    localparam logic [IW:0] LEN_W = (IW + 1)'(LEN);

    logic [7:0] mem [LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Guard keeps a non-power-of-two depth from reading past the array.
    assign rdata = ({1'b0, raddr} < LEN_W) ? mem[raddr] : 8'h00;

endmodule

// File: rtl/nrx_hiscore.sv
// Hi-score controller: buffers the host restore image, waits for the game to initialise
// its score table, writes the image into game RAM, and serves host upload reads live.
module nrx_hiscore
    import nrx_hiscore_pkg::*;
#(
    parameter logic [HS_PORT_AW-1:0] HS_START   = 16'h0E00,
    parameter int                    HS_LEN     = 64,
    parameter logic [HS_PORT_AW-1:0] CHECK_ADDR = 16'h0E3F,
    parameter logic [7:0]            CHECK_VAL  = 8'h00,
    parameter int                    READ_LAT   = 4,
    parameter int                    POLL_DIV   = 16
) (
    input  logic                  CLK24M,
    input  logic                  RESET,
    input  logic                  ioctl_download,
    input  logic                  ioctl_upload,
    input  logic [15:0]           ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    input  logic                  ioctl_wr,
    input  logic                  ioctl_rd,
    output logic [7:0]            ioctl_din,
    output logic                  ioctl_ack,
    output logic [HS_PORT_AW-1:0] hs_address,
    output logic [7:0]            hs_data_out,
    input  logic [7:0]            hs_data_in,
    output logic                  hs_write,
    output logic                  hs_access,
    output logic                  restored,
    output hs_state_e             state_dbg
);

    localparam int              IW       = idx_width(HS_LEN);
    localparam logic [15:0]     LEN16    = 16'(HS_LEN);
    localparam logic [IW-1:0]   LAST_IDX = IW'(HS_LEN - 1);
    localparam logic [3:0]      LAT      = 4'(READ_LAT);

    hs_state_e             state, state_n;
    logic [IW-1:0]         idx, idx_n, buf_raddr;
    logic                  phase, phase_n;
    logic [3:0]            cnt, cnt_n;
    logic [15:0]           up_addr, up_addr_n;
    logic                  pend, pend_n;
    logic [15:0]           pend_addr, pend_addr_n;
    logic                  have, have_n, armed, armed_n;
    logic                  restored_q, restored_n;
    logic                  dl_q;
    logic [POLL_DIV-1:0]   poll_cnt;
    logic [HS_PORT_AW-1:0] addr_q, addr_n;
    logic [7:0]            dout_q, dout_n, din_q, din_n, buf_rdata;
    logic                  wr_q, wr_n, ack_q, ack_n;
    logic                  buf_we, rd_req, dl_rise, dl_fall, poll_wrap;

    // Host strobes carry no back-pressure: ioctl_wr and ioctl_rd are single-cycle
    // valids that are always accepted; ioctl_ack is a single-cycle valid for ioctl_din.
    assign buf_we    = ioctl_download & ioctl_wr & (ioctl_addr < LEN16);
    assign rd_req    = ioctl_upload & ioctl_rd;
    assign dl_rise   = ioctl_download & ~dl_q;
    assign dl_fall   = ~ioctl_download & dl_q;
    assign poll_wrap = &poll_cnt;
    // Looks one byte ahead so the next even phase can load its data directly.
    assign buf_raddr = (state == ST_RESTORE) ? idx + IW'(1) : '0;

    nrx_hs_buf #(.LEN(HS_LEN), .IW(IW)) u_buf (
        .clk   (CLK24M),
        .we    (buf_we),
        .waddr (ioctl_addr[IW-1:0]),
        .wdata (ioctl_dout),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        phase_n     = phase;
        cnt_n       = cnt;
        up_addr_n   = up_addr;
        pend_n      = pend;
        pend_addr_n = pend_addr;
        have_n      = have;
        armed_n     = armed;
        restored_n  = restored_q;
        addr_n      = addr_q;
        dout_n      = dout_q;
        wr_n        = 1'b0;
        ack_n       = 1'b0;
        din_n       = din_q;

        if (rd_req) begin
            pend_n      = 1'b1;
            pend_addr_n = ioctl_addr;
        end
        if (dl_fall && have) begin
            armed_n = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                addr_n = '0;
                dout_n = '0;
                if (pend || rd_req) begin
                    state_n   = ST_UP_RD;
                    up_addr_n = rd_req ? ioctl_addr : pend_addr;
                    pend_n    = 1'b0;
                    cnt_n     = '0;
                    addr_n    = HS_START + up_addr_n;
                end else if (armed && poll_wrap) begin
                    state_n = ST_CHK_RD;
                    cnt_n   = '0;
                    addr_n  = CHECK_ADDR;
                end
            end
            ST_CHK_RD: begin
                if (dl_rise) begin
                    state_n = ST_IDLE;
                    armed_n = 1'b0;
                    have_n  = 1'b0;
                    addr_n  = '0;
                    dout_n  = '0;
                end else if (cnt == LAT) begin
                    if (hs_data_in == CHECK_VAL) begin
                        state_n = ST_RESTORE;
                        idx_n   = '0;
                        phase_n = 1'b0;
                        addr_n  = HS_START;
                        dout_n  = buf_rdata;
                        wr_n    = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        addr_n  = '0;
                    end
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            ST_RESTORE: begin
                if (dl_rise) begin
                    state_n = ST_IDLE;
                    armed_n = 1'b0;
                    have_n  = 1'b0;
                    addr_n  = '0;
                    dout_n  = '0;
                end else if (!phase) begin
                    phase_n = 1'b1;
                end else if (idx == LAST_IDX) begin
                    state_n    = ST_IDLE;
                    restored_n = 1'b1;
                    armed_n    = 1'b0;
                    have_n     = 1'b0;
                    addr_n     = '0;
                    dout_n     = '0;
                end else begin
                    idx_n   = idx + IW'(1);
                    phase_n = 1'b0;
                    addr_n  = HS_START + 16'(idx_n);
                    dout_n  = buf_rdata;
                    wr_n    = 1'b1;
                end
            end
            ST_UP_RD: begin
                if (rd_req) begin
                    // A newer request replaces the one in flight; one ack in total.
                    up_addr_n = ioctl_addr;
                    pend_n    = 1'b0;
                    cnt_n     = '0;
                    addr_n    = HS_START + ioctl_addr;
                end else if (up_addr >= LEN16) begin
                    state_n = ST_IDLE;
                    ack_n   = 1'b1;
                    din_n   = 8'hFF;
                    addr_n  = '0;
                end else if (cnt == LAT) begin
                    state_n = ST_IDLE;
                    ack_n   = 1'b1;
                    din_n   = hs_data_in;
                    addr_n  = '0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (buf_we) begin
            have_n = 1'b1;
        end
    end

    always_ff @(posedge CLK24M) begin
        if (RESET) begin
            state      <= ST_IDLE;
            idx        <= '0;
            phase      <= 1'b0;
            cnt        <= '0;
            up_addr    <= '0;
            pend       <= 1'b0;
            pend_addr  <= '0;
            have       <= 1'b0;
            armed      <= 1'b0;
            restored_q <= 1'b0;
            dl_q       <= 1'b0;
            poll_cnt   <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            wr_q       <= 1'b0;
            ack_q      <= 1'b0;
            din_q      <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            phase      <= phase_n;
            cnt        <= cnt_n;
            up_addr    <= up_addr_n;
            pend       <= pend_n;
            pend_addr  <= pend_addr_n;
            have       <= have_n;
            armed      <= armed_n;
            restored_q <= restored_n;
            dl_q       <= ioctl_download;
            poll_cnt   <= poll_cnt + POLL_DIV'(1);
            addr_q     <= addr_n;
            dout_q     <= dout_n;
            wr_q       <= wr_n;
            ack_q      <= ack_n;
            din_q      <= din_n;
        end
    end

    assign hs_access   = (state != ST_IDLE);
    assign hs_address  = addr_q;
    assign hs_data_out = dout_q;
    assign hs_write    = wr_q;
    assign ioctl_ack   = ack_q;
    assign ioctl_din   = din_q;
    assign restored    = restored_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_nrx_hiscore.sv
// Directed bench for nrx_hiscore: game RAM model with read latency, write log, scoreboard.
module tb_nrx_hiscore;
  import nrx_hiscore_pkg::*;

  localparam int L   = 4;
  localparam int LEN = 64;
  localparam logic [15:0] CHK = 16'h0E3F;

  logic        CLK24M = 1'b0;
  logic        RESET = 1'b1;
  logic        ioctl_download = 1'b0, ioctl_upload = 1'b0;
  logic [15:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wr = 1'b0, ioctl_rd = 1'b0;
  logic [7:0]  ioctl_din;
  logic        ioctl_ack;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_out, hs_data_in;
  logic        hs_write, hs_access, restored;
  hs_state_e   state_dbg;

  nrx_hiscore #(
    .HS_START(16'h0E00), .HS_LEN(LEN), .CHECK_ADDR(CHK), .CHECK_VAL(8'h00),
    .READ_LAT(L), .POLL_DIV(5)
  ) dut (
    .CLK24M(CLK24M), .RESET(RESET),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din), .ioctl_ack(ioctl_ack),
    .hs_address(hs_address), .hs_data_out(hs_data_out), .hs_data_in(hs_data_in),
    .hs_write(hs_write), .hs_access(hs_access), .restored(restored), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 CLK24M = ~CLK24M;

  // game RAM model: writes land on the clock edge, reads return READ_LAT cycles later
  logic [7:0]  ram [65536];
  logic [15:0] pipe [L];
  logic        bk_we = 1'b0;
  logic [15:0] bk_addr = '0;
  logic [7:0]  bk_data = '0;

  always @(posedge CLK24M) begin
    if (hs_write) ram[hs_address] <= hs_data_out;
    if (bk_we) ram[bk_addr] <= bk_data;
    pipe[0] <= hs_address;
    for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
  end
  assign hs_data_in = ram[pipe[L-1]];

  // output monitor: access rises, check polls, write log
  int          rises = 0, polls = 0, wr_cnt = 0, cyc = 0;
  logic        acc_prev = 1'b0;
  logic [15:0] wr_addr [256];
  logic [7:0]  wr_data [256];
  int          wr_cyc [256];
  int          wr_poll [256];

  always @(negedge CLK24M) begin
    cyc++;
    if (hs_access && !acc_prev) begin
      rises++;
      if (hs_address == CHK) polls++;
    end
    acc_prev = hs_access;
    if (hs_write && wr_cnt < 256) begin
      wr_addr[wr_cnt] = hs_address;
      wr_data[wr_cnt] = hs_data_out;
      wr_cyc[wr_cnt]  = cyc;
      wr_poll[wr_cnt] = polls;
      wr_cnt++;
    end
  end

  // scoreboard
  int tests = 0, fails = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks (all entered and left on a falling edge)
  task automatic step(input int n);
    repeat (n) @(negedge CLK24M);
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    bk_addr = a; bk_data = d; bk_we = 1'b1;
    step(1);
    bk_we = 1'b0;
  endtask

  task automatic host_write(input logic [15:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    step(1);
    ioctl_wr = 1'b0;
  endtask

  task automatic download(input logic [7:0] xorv);
    ioctl_download = 1'b1;
    step(1);
    for (int i = 0; i < LEN; i++) host_write(16'(i), 8'(i) ^ xorv);
    ioctl_download = 1'b0;
    step(1);
  endtask

  task automatic host_read(input logic [15:0] a, output int lat, output logic [7:0] d);
    lat = 0; d = '0;
    ioctl_addr = a; ioctl_rd = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      ioctl_rd = 1'b0;
      if (ioctl_ack && lat == 0) begin
        lat = k; d = ioctl_din;
      end
    end
  endtask

  task automatic wait_write_at(input logic [15:0] a, output logic seen);
    int k;
    seen = 1'b0; k = 0;
    while (!seen && k < 600) begin
      if (hs_write && hs_address == a) seen = 1'b1;
      else begin step(1); k++; end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_access"}, 32'(hs_access), 0);
    check({tag, "_write"}, 32'(hs_write), 0);
    check({tag, "_address"}, 32'(hs_address), 0);
    check({tag, "_data_out"}, 32'(hs_data_out), 0);
    check({tag, "_din"}, 32'(ioctl_din), 0);
    check({tag, "_ack"}, 32'(ioctl_ack), 0);
    check({tag, "_restored"}, 32'(restored), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, k, base_rises, base_polls, base_wr;
    logic [7:0] d;
    logic seen;
    logic [23:0] exp;

    // reset values
    step(3);
    check_reset_outputs("reset");
    RESET = 1'b0;
    step(2);

    // out-of-range download: ignored, never arms a restore
    ioctl_download = 1'b1;
    step(1);
    host_write(16'd70, 8'h99);
    ioctl_download = 1'b0;
    base_rises = rises;
    step(100);
    check("oor_dl_no_access", 32'(rises - base_rises), 0);
    check("oor_dl_restored", 32'(restored), 0);

    // upload reads
    poke(16'h0E05, 8'hA7);
    ioctl_upload = 1'b1;
    host_read(16'd5, lat, d);
    check("up_lat_in_range", 32'(lat), L + 2);
    check("up_data_in_range", 32'(d), 32'hA7);
    host_read(16'd64, lat, d);
    check("up_lat_oor", 32'(lat), 2);
    check("up_data_oor", 32'(d), 32'hFF);
    ioctl_upload = 1'b0;

    // restore gated by three failing polls, then a full 64-byte restore
    poke(CHK, 8'h55);
    base_rises = rises; base_polls = polls; base_wr = wr_cnt;
    download(8'h00);
    k = 0;
    while (!((polls - base_polls) >= 3 && !hs_access) && k < 400) begin step(1); k++; end
    check("polls_before_match", 32'(polls - base_polls), 3);
    check("no_write_during_polls", 32'(wr_cnt - base_wr), 0);
    poke(CHK, 8'h00);
    k = 0;
    while (!restored && k < 600) begin step(1); k++; end
    check("restored_set", 32'(restored), 1);
    check("access_released", 32'(hs_access), 0);
    check("restore_write_count", 32'(wr_cnt - base_wr), LEN);
    check("access_rises", 32'(rises - base_rises), 4);
    check("restore_after_poll4", 32'(wr_poll[base_wr] - base_polls), 4);
    for (int i = 0; i < LEN; i++) exp_q.push_back({16'h0E00 + 16'(i), 8'(i)});
    for (int i = 0; i < LEN; i++) begin
      exp = exp_q.pop_front();
      check("restore_write", {8'h00, wr_addr[base_wr + i], wr_data[base_wr + i]}, {8'h00, exp});
      if (i > 0) check("restore_gap", 32'(wr_cyc[base_wr + i] - wr_cyc[base_wr + i - 1]), 2);
    end
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    check("restored_cleared_by_reset", 32'(restored), 0);

    // abort by a new download at byte 10
    poke(CHK, 8'h00);
    download(8'h5A);
    wait_write_at(16'h0E0A, seen);
    check("abort_byte10_seen", 32'(seen), 1);
    ioctl_download = 1'b1;
    step(1);
    check("abort_write", 32'(hs_write), 0);
    check("abort_access", 32'(hs_access), 0);
    check("abort_restored", 32'(restored), 0);
    ioctl_download = 1'b0;
    base_rises = rises;
    step(100);
    check("abort_not_rearmed", 32'(rises - base_rises), 0);
    check("abort_restored_later", 32'(restored), 0);

    // reset mid-restore
    download(8'h33);
    wait_write_at(16'h0E14, seen);
    check("midreset_byte20_seen", 32'(seen), 1);
    RESET = 1'b1;
    step(1);
    check_reset_outputs("midreset");
    RESET = 1'b0;
    base_rises = rises;
    step(100);
    check("midreset_not_rearmed", 32'(rises - base_rises), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
